// File: rtl/quad_encoder_bank_if.sv
// Pin-side and control-side signal bundle for the quadrature encoder bank.
// master drives raw pins and controls; slave is the decoder bank.
interface quad_encoder_bank_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]       enc_a;
    logic [CHANNELS-1:0]       enc_b;
    logic [CHANNELS-1:0]       btn_n;
    logic [1:0]                res;
    logic                      wrap_en;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS*CNT_W-1:0] count;
    logic [CHANNELS-1:0]       step;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       err;
    logic [CHANNELS-1:0]       btn_press;
    logic [CHANNELS-1:0]       btn_held;

    modport master (
        output enc_a, enc_b, btn_n, res, wrap_en, clr,
        input  count, step, dir, err, btn_press, btn_held
    );

    modport slave (
        input  enc_a, enc_b, btn_n, res, wrap_en, clr,
        output count, step, dir, err, btn_press, btn_held
    );
endinterface

// File: rtl/quad_encoder_bank.sv
// Bank of quadrature decoders with per-channel position counters and
// debounced pushbuttons; every raw pin is synchronised before use.
module quad_encoder_bank #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    quad_encoder_bank_if.slave bus
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    // Marks when the synchroniser + sample register hold real pin data after reset.
    logic [SYNC_STAGES:0] vld_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_reg <= '0;
        else     vld_reg <= {vld_reg[SYNC_STAGES-1:0], 1'b1};
    end

    logic [CHANNELS*CNT_W-1:0] count_vec;
    logic [CHANNELS-1:0]       step_vec, dir_vec, err_vec, press_vec, held_vec;

    function automatic logic [1:0] cw_next(input logic [1:0] s);
        case (s)
            2'b00:   cw_next = 2'b10;
            2'b10:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b01;
            default: cw_next = 2'b00;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] a_sync_reg, b_sync_reg, n_sync_reg;
            logic [1:0]             ab_reg, prev_reg;
            logic                   primed_reg;
            logic [CNT_W-1:0]       count_reg, count_next;
            logic                   step_reg, dir_reg, err_reg;
            logic                   fwd, bwd, illegal, gate, counted;
            logic                   deb_reg, press_reg;
            logic [DEB_W-1:0]       deb_cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_sync_reg <= '0;
                    b_sync_reg <= '0;
                    n_sync_reg <= '1;
                end else begin
                    a_sync_reg <= {a_sync_reg[SYNC_STAGES-2:0], bus.enc_a[gi]};
                    b_sync_reg <= {b_sync_reg[SYNC_STAGES-2:0], bus.enc_b[gi]};
                    n_sync_reg <= {n_sync_reg[SYNC_STAGES-2:0], bus.btn_n[gi]};
                end
            end

            always_comb begin
                fwd     = primed_reg && (ab_reg == cw_next(prev_reg));
                bwd     = primed_reg && (prev_reg == cw_next(ab_reg));
                illegal = primed_reg && ((ab_reg ^ prev_reg) == 2'b11);
                case (bus.res)
                    2'b00:   gate = (ab_reg == 2'b00);
                    2'b01:   gate = (ab_reg == 2'b00) || (ab_reg == 2'b11);
                    default: gate = 1'b1;
                endcase
                counted    = (fwd || bwd) && gate;
                count_next = count_reg;
                if (fwd) begin
                    if (bus.wrap_en || (count_reg != '1)) count_next = count_reg + 1'b1;
                end else if (bwd) begin
                    if (bus.wrap_en || (count_reg != '0)) count_next = count_reg - 1'b1;
                end
            end

            // prev tracks the sample every cycle; decoding is suppressed until primed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ab_reg     <= 2'b00;
                    prev_reg   <= 2'b00;
                    primed_reg <= 1'b0;
                    count_reg  <= '0;
                    step_reg   <= 1'b0;
                    dir_reg    <= 1'b0;
                    err_reg    <= 1'b0;
                end else begin
                    step_reg   <= 1'b0;
                    ab_reg     <= {a_sync_reg[SYNC_STAGES-1], b_sync_reg[SYNC_STAGES-1]};
                    prev_reg   <= ab_reg;
                    primed_reg <= primed_reg | vld_reg[SYNC_STAGES];
                    if (bus.clr[gi]) begin
                        count_reg <= '0;
                        err_reg   <= 1'b0;
                    end else begin
                        if (counted) begin
                            count_reg <= count_next;
                            step_reg  <= 1'b1;
                            dir_reg   <= fwd;
                        end
                        if (illegal) err_reg <= 1'b1;
                    end
                end
            end

            // Level flips on the sample after DEB_CYCLES consecutive disagreements.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    deb_reg     <= 1'b1;
                    deb_cnt_reg <= '0;
                    press_reg   <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (n_sync_reg[SYNC_STAGES-1] != deb_reg) begin
                        if (deb_cnt_reg == DEB_W'(DEB_CYCLES)) begin
                            deb_reg     <= n_sync_reg[SYNC_STAGES-1];
                            deb_cnt_reg <= '0;
                            press_reg   <= ~n_sync_reg[SYNC_STAGES-1];
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + 1'b1;
                        end
                    end else begin
                        deb_cnt_reg <= '0;
                    end
                end
            end

            assign count_vec[gi*CNT_W +: CNT_W] = count_reg;
            assign step_vec[gi]  = step_reg;
            assign dir_vec[gi]   = dir_reg;
            assign err_vec[gi]   = err_reg;
            assign press_vec[gi] = press_reg;
            assign held_vec[gi]  = ~deb_reg;
        end
    endgenerate

    assign bus.count     = count_vec;
    assign bus.step      = step_vec;
    assign bus.dir       = dir_vec;
    assign bus.err       = err_vec;
    assign bus.btn_press = press_vec;
    assign bus.btn_held  = held_vec;
endmodule
